// File: rtl/uart_buf_pkg.sv
// Shared types and constants for the UART console line buffer.
package uart_buf_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [7:0] NEWLINE         = 8'h0A;
    localparam int         DROP_CNT_W      = 16;
    localparam int         DEFAULT_DEPTH   = 64;
    localparam int         DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/uart_buf_fifo.sv
// Character FIFO: storage, wrapping pointers and a registered occupancy count.
module uart_buf_fifo #(
    parameter int DEPTH = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             din,
    output logic [7:0]             head,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [LW-1:0] level_reg;
    logic          do_push;
    logic          do_pop;

    // Space is judged on the registered level, so a same-cycle pop never makes room.
    assign do_push = push && (level_reg < LW'(DEPTH));
    assign do_pop  = pop && (level_reg != '0);

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            level_reg <= level_reg + LW'(do_push) - LW'(do_pop);
        end
    end

    // Head is read straight from the array so it is presented the cycle a segment opens.
    assign head  = mem[rd_ptr_reg];
    assign level = level_reg;

endmodule

// File: rtl/uart_line_buffer.sv
// Line-oriented UART console buffer: collects characters and releases them as segments
// on newline, full FIFO or idle timeout.
module uart_line_buffer
    import uart_buf_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_ch,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_ch,
    output logic                  out_last,
    output logic [$clog2(DEPTH):0] level,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  overflow
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    state_t          state_reg;
    state_t          state_next;
    logic [LW-1:0]   remaining_reg;
    logic [TW-1:0]   idle_cnt_reg;
    logic            flush_pend_reg;
    logic [DROP_CNT_W-1:0] drop_cnt_reg;
    logic            overflow_reg;

    logic [7:0]      head;
    logic [LW-1:0]   fifo_level;
    logic            push_ok;
    logic            drop_evt;
    logic            pop_ok;
    logic            is_nl;
    logic            trig_fill;
    logic            enter_drain;
    logic [LW-1:0]   seg_len;

    uart_buf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_ok),
        .pop   (pop_ok),
        .din   (in_ch),
        .head  (head),
        .level (fifo_level)
    );

    assign push_ok  = in_valid && (fifo_level < LW'(DEPTH));
    assign drop_evt = in_valid && !push_ok;
    assign pop_ok   = out_valid && out_ready;
    assign is_nl    = push_ok && (in_ch == NEWLINE);

    assign trig_fill = is_nl
                    || (fifo_level == LW'(DEPTH))
                    || ((fifo_level != '0) && (idle_cnt_reg == TW'(TIMEOUT - 1)))
                    || flush_pend_reg;

    // Only a newline pushed this cycle joins the segment; any other push waits for the next one.
    assign seg_len     = is_nl ? fifo_level + LW'(1) : fifo_level;
    assign enter_drain = (state_reg == FILL) && (state_next == DRAIN);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            FILL:  if (trig_fill) state_next = DRAIN;
            DRAIN: if (pop_ok && (remaining_reg == LW'(1))) state_next = FILL;
        endcase
    end

    always_comb begin
        out_valid = (state_reg == DRAIN);
        out_last  = out_valid && (remaining_reg == LW'(1));
        out_ch    = out_valid ? head : 8'h00;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            remaining_reg  <= '0;
            idle_cnt_reg   <= '0;
            flush_pend_reg <= 1'b0;
            drop_cnt_reg   <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            if (enter_drain) begin
                remaining_reg <= seg_len;
            end else if (pop_ok) begin
                remaining_reg <= remaining_reg - LW'(1);
            end

            // A newline arriving mid-segment is remembered and flushed right after it.
            if ((state_reg == DRAIN) && is_nl) begin
                flush_pend_reg <= 1'b1;
            end else if (enter_drain) begin
                flush_pend_reg <= 1'b0;
            end

            if ((state_reg == DRAIN) || (state_next == DRAIN) || push_ok || (fifo_level == '0)) begin
                idle_cnt_reg <= '0;
            end else if (idle_cnt_reg != TW'(TIMEOUT - 1)) begin
                idle_cnt_reg <= idle_cnt_reg + TW'(1);
            end

            if (drop_evt) begin
                overflow_reg <= 1'b1;
                if (drop_cnt_reg != '1) begin
                    drop_cnt_reg <= drop_cnt_reg + DROP_CNT_W'(1);
                end
            end
        end
    end

    assign level    = fifo_level;
    assign drop_cnt = drop_cnt_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_uart_line_buffer.sv
// Bench for uart_line_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_line_buffer;

    localparam int DEPTH   = 64;
    localparam int TIMEOUT = 16;
    localparam logic [7:0] NL = 8'h0A;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_ch = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_ch;
    logic       out_last;
    logic [6:0] level;
    logic [15:0] drop_cnt;
    logic       overflow;

    uart_line_buffer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset     (rst_n),
        .in_valid  (in_valid),
        .in_ch     (in_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_last  (out_last),
        .level     (level),
        .drop_cnt  (drop_cnt),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a plain character queue plus segment bookkeeping.
    logic [7:0] m_q[$];
    bit  m_drain = 0;
    int  m_seg   = 0;
    bit  m_pend  = 0;
    int  m_quiet = 0;
    int  m_drops = 0;
    bit  m_ovf   = 0;
    int  m_sz;
    bit  m_acc;
    bit  m_nl;

    initial begin
        forever begin
            @(posedge clock or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_drain = 0; m_seg = 0; m_pend = 0; m_quiet = 0; m_drops = 0; m_ovf = 0;
            end else begin
                m_sz  = m_q.size();
                m_acc = in_valid && (m_sz < DEPTH);
                m_nl  = m_acc && (in_ch == NL);
                if (in_valid && !m_acc) begin
                    m_ovf = 1;
                    if (m_drops < 65535) m_drops++;
                end
                if (m_drain) begin
                    if (out_ready) begin
                        void'(m_q.pop_front());
                        m_seg--;
                        if (m_seg == 0) m_drain = 0;
                    end
                    if (m_acc) m_q.push_back(in_ch);
                    if (m_nl) m_pend = 1;
                    m_quiet = 0;
                end else begin
                    if (m_acc) m_q.push_back(in_ch);
                    if (m_nl || m_sz == DEPTH || (m_sz > 0 && m_quiet == TIMEOUT - 1) || m_pend) begin
                        m_drain = 1;
                        m_seg   = m_nl ? m_sz + 1 : m_sz;
                        m_pend  = 0;
                        m_quiet = 0;
                    end else if (m_acc || m_sz == 0) begin
                        m_quiet = 0;
                    end else begin
                        m_quiet++;
                    end
                end
            end
        end
    end

    // Transfer log and per-cycle comparison against the model.
    logic [7:0] xf_ch[$];
    bit         xf_last[$];
    int         xf_cyc[$];
    int         vld_seen = 0;
    logic [7:0] e_ch;
    bit         e_last;
    bit         bad;

    initial begin
        forever begin
            @(negedge clock);
            if (rst_n) begin
                if (out_valid) vld_seen++;
                if (out_valid && out_ready) begin
                    xf_ch.push_back(out_ch);
                    xf_last.push_back(out_last);
                    xf_cyc.push_back(cyc);
                end
                e_ch   = (m_q.size() > 0) ? m_q[0] : 8'h00;
                e_last = m_drain && (m_seg == 1);
                bad = (out_valid !== m_drain) || (int'(level) != m_q.size())
                   || (int'(drop_cnt) != m_drops) || (overflow !== m_ovf)
                   || (out_last !== e_last)
                   || (m_drain && (out_ch !== e_ch));
                n_checks++;
                if (!bad) n_pass++;
                else $display("FAIL model cyc=%0d got v=%0b l=%0b ch=%02h lvl=%0d drp=%0d ovf=%0b exp v=%0b l=%0b ch=%02h lvl=%0d drp=%0d ovf=%0b",
                              cyc, out_valid, out_last, out_ch, level, drop_cnt, overflow,
                              m_drain, e_last, e_ch, m_q.size(), m_drops, m_ovf);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        xf_ch.delete();
        xf_last.delete();
        xf_cyc.delete();
    endtask

    int t_mark;
    int n_last;
    logic [7:0] s3 [3] = '{8'h68, 8'h69, 8'h0A};
    logic [7:0] s6 [6] = '{8'h61, 8'h62, 8'h63, 8'h0A, 8'h78, 8'h0A};
    bit         l6 [6] = '{0, 0, 0, 1, 0, 1};
    int rate_in  [6] = '{70, 20, 90, 5, 60, 95};
    int rate_rdy [6] = '{80, 90, 10, 50, 50, 30};

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("reset_out_valid", out_valid, 0);
        check("reset_level", level, 0);
        check("reset_drop_cnt", drop_cnt, 0);
        check("reset_overflow", overflow, 0);

        // "hi\n" back to back with the consumer always ready
        out_ready = 1; clear_log();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_ch = s3[i];
            if (i == 2) t_mark = cyc;
            tick();
        end
        in_valid = 0;
        repeat (6) tick();
        check("hi_count", xf_ch.size(), 3);
        if (xf_ch.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("hi_char", xf_ch[i], s3[i]);
                check("hi_last", xf_last[i], (i == 2) ? 1 : 0);
            end
            check("hi_latency", xf_cyc[0], t_mark + 1);
        end
        check("hi_level_empty", level, 0);

        // "ab" then idle: 16 idle cycles after 'b', flushed on the next one
        clear_log();
        in_valid = 1; in_ch = 8'h61; tick();
        in_ch = 8'h62; t_mark = cyc; tick();
        in_valid = 0;
        repeat (25) tick();
        check("idle_count", xf_ch.size(), 2);
        if (xf_ch.size() == 2) begin
            check("idle_char0", xf_ch[0], 8'h61);
            check("idle_char1", xf_ch[1], 8'h62);
            check("idle_last0", xf_last[0], 0);
            check("idle_last1", xf_last[1], 1);
            check("idle_rise", xf_cyc[0], t_mark + 17);
        end

        // 70 characters, no newline, consumer stalled
        out_ready = 0; clear_log();
        for (int i = 0; i < 70; i++) begin
            in_valid = 1; in_ch = 8'h41 + 8'(i % 26);
            tick();
        end
        in_valid = 0;
        tick();
        check("full_level", level, 64);
        check("full_drop_cnt", drop_cnt, 6);
        check("full_overflow", overflow, 1);
        check("full_out_valid", out_valid, 1);
        check("full_first_ch", out_ch, 8'h41);
        out_ready = 1;
        repeat (70) tick();
        check("full_count", xf_ch.size(), 64);
        n_last = 0;
        foreach (xf_last[i]) n_last += int'(xf_last[i]);
        check("full_last_count", n_last, 1);
        if (xf_ch.size() == 64) begin
            check("full_last_pos", xf_last[63], 1);
            check("full_last_ch", xf_ch[63], 8'h41 + 8'(63 % 26));
        end

        // "x\n" pushed while a 4-character segment drains with toggling ready
        out_ready = 0; clear_log();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_ch = s6[i]; tick();
        end
        in_ch = 8'h78; out_ready = 1; tick();
        in_ch = NL; out_ready = 0; tick();
        in_valid = 0;
        for (int i = 0; i < 20; i++) begin
            out_ready = i[0]; tick();
        end
        out_ready = 1;
        repeat (10) tick();
        check("pend_count", xf_ch.size(), 6);
        if (xf_ch.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                check("pend_char", xf_ch[i], s6[i]);
                check("pend_last", xf_last[i], l6[i]);
            end
        end

        // reset mid-segment with 10 characters left
        out_ready = 1; clear_log();
        for (int i = 0; i < 12; i++) begin
            in_valid = 1; in_ch = (i == 11) ? NL : 8'h41 + 8'(i);
            tick();
        end
        in_valid = 0;
        tick(); tick();
        out_ready = 0;
        check("mid_out_valid", out_valid, 1);
        check("mid_level", level, 10);
        #2 rst_n = 0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_level", level, 0);
        repeat (2) tick();
        rst_n = 1;
        vld_seen = 0;
        out_ready = 1;
        repeat (40) tick();
        check("post_rst_quiet", vld_seen, 0);
        check("post_rst_drop_cnt", drop_cnt, 0);
        check("post_rst_overflow", overflow, 0);

        // newline at level 63 fills exactly to DEPTH without a drop
        out_ready = 0; clear_log();
        for (int i = 0; i < 64; i++) begin
            in_valid = 1; in_ch = (i == 63) ? NL : 8'h61 + 8'(i % 26);
            tick();
        end
        in_valid = 0;
        tick();
        check("nl63_drop_cnt", drop_cnt, 0);
        check("nl63_level", level, 64);
        check("nl63_out_valid", out_valid, 1);
        out_ready = 1;
        repeat (70) tick();
        check("nl63_count", xf_ch.size(), 64);
        n_last = 0;
        foreach (xf_last[i]) n_last += int'(xf_last[i]);
        check("nl63_last_count", n_last, 1);
        if (xf_ch.size() == 64) begin
            check("nl63_last_pos", xf_last[63], 1);
            check("nl63_last_ch", xf_ch[63], NL);
        end

        // randomized traffic in phases of differing input/consumer rates
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 500; c++) begin
                in_valid  = ($urandom_range(0, 99) < rate_in[p]);
                in_ch     = ($urandom_range(0, 9) == 0) ? NL : 8'($urandom_range(0, 255));
                out_ready = ($urandom_range(0, 99) < rate_rdy[p]);
                tick();
            end
        end
        in_valid = 0; out_ready = 1;
        repeat (100) tick();
        check("final_level", level, 0);
        check("final_out_valid", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
